// File: rtl/vga_sched_pkg.sv
// vga_sched_pkg: 1024x768@60 timing defaults, phase enum and BCD word type
package vga_sched_pkg;
  localparam int H_ACTIVE = 1024;
  localparam int H_FP = 24;
  localparam int H_SYNC = 136;
  localparam int H_BP = 160;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 768;
  localparam int V_FP = 3;
  localparam int V_SYNC = 6;
  localparam int V_BP = 29;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW = 11;
  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_e;
  typedef logic [23:0] bcd_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis, counter plus ACTIVE/FP/SYNC/BP phase FSM
module vga_axis_counter
  import vga_sched_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP = H_FP,
  parameter int SYNC = H_SYNC,
  parameter int BP = H_BP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [CW-1:0] cnt_o,
  output phase_e        phase_o,
  output logic          wrap_o
);
  localparam logic [CW-1:0] LAST = CW'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [CW-1:0] B_FP = CW'(ACTIVE);
  localparam logic [CW-1:0] B_SYNC = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] B_BP = CW'(ACTIVE + FP + SYNC);
  logic [CW-1:0] cnt_q, cnt_d;
  phase_e ph_q, ph_d;
  assign wrap_o = adv_i && cnt_q == LAST;
  assign cnt_o = cnt_q;
  assign phase_o = ph_q;
  // next count and the phase that count falls into
  always_comb begin
    cnt_d = cnt_q;
    ph_d = ph_q;
    if (clr_i) begin
      cnt_d = '0;
      ph_d = PH_ACTIVE;
    end else if (adv_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      ph_d = cnt_d == B_FP ? PH_FP : cnt_d == B_SYNC ? PH_SYNC :
             cnt_d == B_BP ? PH_BP : cnt_d == '0 ? PH_ACTIVE : ph_q;
    end
  end
  // counter and phase state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ph_q <= PH_ACTIVE;
    end else begin
      cnt_q <= cnt_d;
      ph_q <= ph_d;
    end
  end
endmodule

// File: rtl/vga_frame_sched.sv
// vga_frame_sched: VGA timing, sync/enable outputs and tear-free BCD commit; VGA_SCHED_FRAME_CNT_EN adds FRAME_CNT
module vga_frame_sched
  import vga_sched_pkg::*;
#(
  parameter int HACT = H_ACTIVE,
  parameter int HFP = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP = H_BP,
  parameter int VACT = V_ACTIVE,
  parameter int VFP = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP = V_BP
) (
  input  logic        VGA_CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  bcd_t        NUM_IN,
  input  logic        NUM_VLD,
  output logic        NUM_RDY,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_IF_RGBEN,
  output logic        FRAME_START,
  output bcd_t        NUMBER_BCD,
  output logic [15:0] FRAME_CNT
);
  logic [CW-1:0] hcnt, vcnt;
  phase_e hph, vph;
  logic hwrap, vwrap;
  logic hs_q, vs_q, rgb_q, fs_q, org_q, rdy_q;
  bcd_t shd_q, bcd_q;
  logic commit, xfer;
  vga_axis_counter #(.ACTIVE(HACT), .FP(HFP), .SYNC(HSYNC), .BP(HBP)) u_h (
    .clk(VGA_CLK), .rst(RST_N), .clr_i(!EN), .adv_i(EN),
    .cnt_o(hcnt), .phase_o(hph), .wrap_o(hwrap)
  );
  vga_axis_counter #(.ACTIVE(VACT), .FP(VFP), .SYNC(VSYNC), .BP(VBP)) u_v (
    .clk(VGA_CLK), .rst(RST_N), .clr_i(!EN), .adv_i(hwrap),
    .cnt_o(vcnt), .phase_o(vph), .wrap_o(vwrap)
  );
  assign commit = EN && !rdy_q && hcnt == '0 && vcnt == CW'(VACT);
  assign xfer = NUM_VLD && rdy_q;
  // registered video outputs; org_q marks that the counters sit at 0,0
  always_ff @(posedge VGA_CLK) begin
    if (RST_N) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      rgb_q <= 1'b0;
      fs_q <= 1'b0;
      org_q <= 1'b1;
    end else begin
      hs_q <= !(EN && hph == PH_SYNC);
      vs_q <= !(EN && vph == PH_SYNC);
      rgb_q <= EN && hph == PH_ACTIVE && vph == PH_ACTIVE;
      fs_q <= EN && org_q;
      org_q <= !EN || vwrap;
    end
  end
  // single-entry shadow, committed at the first blanking line
  always_ff @(posedge VGA_CLK) begin
    if (RST_N) begin
      rdy_q <= 1'b1;
      shd_q <= '0;
      bcd_q <= '0;
    end else begin
      if (xfer) shd_q <= NUM_IN;
      if (commit) bcd_q <= shd_q;
      rdy_q <= commit ? 1'b1 : xfer ? 1'b0 : rdy_q;
    end
  end
`ifdef VGA_SCHED_FRAME_CNT_EN
  logic [15:0] fc_q;
  // frame counter steps once per FRAME_START pulse
  always_ff @(posedge VGA_CLK) begin
    if (RST_N) fc_q <= '0;
    else fc_q <= fc_q + 16'(fs_q);
  end
  assign FRAME_CNT = fc_q;
`else
  assign FRAME_CNT = '0;
`endif
  assign NUM_RDY = rdy_q;
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;
  assign VGA_IF_RGBEN = rgb_q;
  assign FRAME_START = fs_q;
  assign NUMBER_BCD = bcd_q;
endmodule

// File: tb/tb_vga_frame_sched.sv
// tb_vga_frame_sched: directed checks on a shrunken-timing instance plus the first line of a full-timing one
module tb_vga_frame_sched;
`ifdef VGA_SCHED_FRAME_CNT_EN
  localparam logic [23:0] FC1 = 24'd1;
`else
  localparam logic [23:0] FC1 = 24'd0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, rf = 1'b1, en = 1'b1, vld = 1'b0;
  logic [23:0] num = '0;
  logic rdy, hs, vs, rgb, fs;
  logic [23:0] bcd;
  logic [15:0] fc;
  logic f_rdy, f_hs, f_vs, f_rgb, f_fs;
  logic [23:0] f_bcd;
  logic [15:0] f_fc;
  int checks = 0, failures = 0, k = -1;
  vga_frame_sched #(.HACT(8), .HFP(2), .HSYNC(3), .HBP(3),
                    .VACT(4), .VFP(1), .VSYNC(2), .VBP(2)) dut (
    .VGA_CLK(clk), .RST_N(rst), .EN(en), .NUM_IN(num), .NUM_VLD(vld),
    .NUM_RDY(rdy), .VGA_HS(hs), .VGA_VS(vs), .VGA_IF_RGBEN(rgb),
    .FRAME_START(fs), .NUMBER_BCD(bcd), .FRAME_CNT(fc)
  );
  vga_frame_sched u_full (
    .VGA_CLK(clk), .RST_N(rf), .EN(1'b1), .NUM_IN(24'h0), .NUM_VLD(1'b0),
    .NUM_RDY(f_rdy), .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_IF_RGBEN(f_rgb),
    .FRAME_START(f_fs), .NUMBER_BCD(f_bcd), .FRAME_CNT(f_fc)
  );
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask
  task automatic go(input int t);
    while (k < t) begin
      @(negedge clk);
      k++;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hs", hs, 1); chk("rst_vs", vs, 1); chk("rst_rgb", rgb, 0);
    chk("rst_fs", fs, 0); chk("rst_bcd", bcd, 0); chk("rst_rdy", rdy, 1);
    chk("rst_fc", fc, 0);
    rst = 1'b0;
    rf = 1'b0;
    go(0);
    chk("fs0", fs, 1); chk("rgb0", rgb, 1); chk("hs0", hs, 1); chk("vs0", vs, 1);
    chk("full_fs0", f_fs, 1); chk("full_rgb0", f_rgb, 1);
    go(1); chk("fs1", fs, 0); chk("fc1", fc, FC1);
    go(7); chk("rgb_last", rgb, 1);
    go(8); chk("rgb_fp", rgb, 0);
    go(9); chk("hs_fp", hs, 1);
    go(10); chk("hs_sync0", hs, 0);
    go(12); chk("hs_sync2", hs, 0);
    go(13); chk("hs_bp", hs, 1);
    go(16); chk("rgb_line1", rgb, 1); chk("fs_line1", fs, 0);
    go(20); chk("rdy_pre", rdy, 1);
    num = 24'h123456;
    vld = 1'b1;
    go(21); chk("rdy_drop", rdy, 0);
    num = 24'h000001;
    go(63); chk("bcd_hold", bcd, 24'h0); chk("rdy_stall", rdy, 0);
    go(64); chk("bcd_commit", bcd, 24'h123456); chk("rdy_rise", rdy, 1); chk("rgb_blank", rgb, 0);
    go(65); chk("rdy_second", rdy, 0); chk("bcd_keep", bcd, 24'h123456);
    vld = 1'b0;
    go(79); chk("vs_fp", vs, 1);
    go(80); chk("vs_sync0", vs, 0);
    go(111); chk("vs_sync_end", vs, 0);
    go(112); chk("vs_bp", vs, 1);
    go(143); chk("fs_pre2", fs, 0);
    go(144); chk("fs_frame2", fs, 1);
    go(207); chk("bcd_f2_hold", bcd, 24'h123456);
    go(208); chk("bcd_commit2", bcd, 24'h000001); chk("rdy_rise2", rdy, 1);
    go(378); chk("hs_before_off", hs, 0); chk("vs_before_off", vs, 0);
    en = 1'b0;
    go(379); chk("off_hs", hs, 1); chk("off_vs", vs, 1); chk("off_rgb", rgb, 0); chk("off_fs", fs, 0);
    go(380);
    num = 24'h654321;
    vld = 1'b1;
    go(381); chk("off_xfer", rdy, 0);
    vld = 1'b0;
    go(428); chk("off_fs_end", fs, 0); chk("off_rgb_end", rgb, 0);
    en = 1'b1;
    go(429); chk("on_fs", fs, 1); chk("on_rgb", rgb, 1); chk("on_hs", hs, 1);
    go(492); chk("bcd_pre3", bcd, 24'h000001);
    go(493); chk("bcd_commit3", bcd, 24'h654321); chk("rdy_rise3", rdy, 1);
    go(500);
    num = 24'h987654;
    vld = 1'b1;
    go(501); chk("rdy_drop4", rdy, 0);
    vld = 1'b0;
    go(510); chk("vs_before_rst", vs, 0);
    rst = 1'b1;
    go(511);
    chk("mrst_bcd", bcd, 0); chk("mrst_rdy", rdy, 1); chk("mrst_hs", hs, 1);
    chk("mrst_vs", vs, 1); chk("mrst_rgb", rgb, 0); chk("mrst_fs", fs, 0); chk("mrst_fc", fc, 0);
    rst = 1'b0;
    go(512); chk("post_rst_fs", fs, 1);
    go(576); chk("no_stale_commit", bcd, 0); chk("rdy_after_rst", rdy, 1);
    go(1023); chk("full_rgb_last", f_rgb, 1);
    go(1024); chk("full_rgb_off", f_rgb, 0);
    go(1047); chk("full_hs_fp", f_hs, 1);
    go(1048); chk("full_hs_sync", f_hs, 0);
    go(1183); chk("full_hs_sync_end", f_hs, 0);
    go(1184); chk("full_hs_bp", f_hs, 1); chk("full_vs", f_vs, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
